// File: rtl/fft8_sched.sv
// fft8_sched: load/compute/unload sequencer for an 8-point in-place radix-2 FFT.
// Optional inverse-transform support via re/im swap is enabled by FFT8_SCHED_INV_EN.
//
// state  | meaning
// LOAD   | accept 8 samples, store at bit-reversed addresses
// CALC   | issue 3 stages x 4 butterflies, one per cycle, write back in place
// UNLOAD | stream buffer[0..7] in natural order
module fft8_sched #(
  parameter  int N = 3,
  localparam int W = 2**N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_r,
  input  logic [W-1:0] in_i,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_r,
  output logic [W-1:0] out_i,
  output logic         out_last,
  output logic         busy,
  output logic [W-1:0] bf_in_1_r,
  output logic [W-1:0] bf_in_1_i,
  output logic [W-1:0] bf_in_2_r,
  output logic [W-1:0] bf_in_2_i,
  output logic [1:0]   bf_tw,
  input  logic [W-1:0] bf_out_1_r,
  input  logic [W-1:0] bf_out_1_i,
  input  logic [W-1:0] bf_out_2_r,
  input  logic [W-1:0] bf_out_2_i
`ifdef FFT8_SCHED_INV_EN
  ,
  input  logic         inv
`endif
);

  typedef enum logic [1:0] {LOAD, CALC, UNLOAD} state_t;

  state_t       state_q, state_d;
  logic [2:0]   ld_cnt_q, ld_cnt_d;
  logic [1:0]   stage_q, stage_d;
  logic [1:0]   bfly_q, bfly_d;
  logic [2:0]   out_cnt_q, out_cnt_d;
  logic         load_we, calc_we;
  logic         swap_ld, swap_ul;
  logic [2:0]   top_idx, bot_idx;
  logic [1:0]   tw;
  logic [2*W-1:0] ul_entry;

  logic [2*W-1:0] buffer [8];

`ifdef FFT8_SCHED_INV_EN
  logic inv_q;

  always_ff @(posedge clk) begin
    if (rst)
      inv_q <= 1'b0;
    else if (load_we && ld_cnt_q == 3'd0)
      inv_q <= inv;
  end

  // The first sample must already use the newly sampled mode.
  assign swap_ld = (ld_cnt_q == 3'd0) ? inv : inv_q;
  assign swap_ul = inv_q;
`else
  assign swap_ld = 1'b0;
  assign swap_ul = 1'b0;
`endif

  // Butterfly addressing: span = 1<<s, top = (b>>s)*2*span + (b & (span-1)).
  always_comb begin
    top_idx = {bfly_q, 1'b0};
    tw      = 2'd0;
    case (stage_q)
      2'd1: begin
        top_idx = {bfly_q[1], 1'b0, bfly_q[0]};
        tw      = {bfly_q[0], 1'b0};
      end
      2'd2: begin
        top_idx = {1'b0, bfly_q};
        tw      = bfly_q;
      end
      default: ;
    endcase
    bot_idx = top_idx | (3'd1 << stage_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= LOAD;
      ld_cnt_q  <= 3'd0;
      stage_q   <= 2'd0;
      bfly_q    <= 2'd0;
      out_cnt_q <= 3'd0;
    end else begin
      state_q   <= state_d;
      ld_cnt_q  <= ld_cnt_d;
      stage_q   <= stage_d;
      bfly_q    <= bfly_d;
      out_cnt_q <= out_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ld_cnt_d  = ld_cnt_q;
    stage_d   = stage_q;
    bfly_d    = bfly_q;
    out_cnt_d = out_cnt_q;
    load_we   = 1'b0;
    calc_we   = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_r     = '0;
    out_i     = '0;
    out_last  = 1'b0;
    busy      = 1'b0;
    bf_in_1_r = '0;
    bf_in_1_i = '0;
    bf_in_2_r = '0;
    bf_in_2_i = '0;
    bf_tw     = 2'd0;
    ul_entry  = buffer[out_cnt_q];
    if (!rst) begin
      case (state_q)
        LOAD: begin
          in_ready = 1'b1;
          if (in_valid) begin
            load_we  = 1'b1;
            ld_cnt_d = ld_cnt_q + 3'd1;
            if (ld_cnt_q == 3'd7)
              state_d = CALC;
          end
        end
        CALC: begin
          busy      = 1'b1;
          calc_we   = 1'b1;
          bf_in_1_r = buffer[top_idx][2*W-1:W];
          bf_in_1_i = buffer[top_idx][W-1:0];
          bf_in_2_r = buffer[bot_idx][2*W-1:W];
          bf_in_2_i = buffer[bot_idx][W-1:0];
          bf_tw     = tw;
          if (bfly_q == 2'd3) begin
            bfly_d = 2'd0;
            if (stage_q == 2'd2) begin
              stage_d = 2'd0;
              state_d = UNLOAD;
            end else begin
              stage_d = stage_q + 2'd1;
            end
          end else begin
            bfly_d = bfly_q + 2'd1;
          end
        end
        UNLOAD: begin
          out_valid = 1'b1;
          out_r     = swap_ul ? ul_entry[W-1:0] : ul_entry[2*W-1:W];
          out_i     = swap_ul ? ul_entry[2*W-1:W] : ul_entry[W-1:0];
          out_last  = (out_cnt_q == 3'd7);
          if (out_ready) begin
            out_cnt_d = out_cnt_q + 3'd1;
            if (out_cnt_q == 3'd7)
              state_d = LOAD;
          end
        end
        default: state_d = LOAD;
      endcase
    end
  end

  // Buffer is deliberately not reset; each LOAD overwrites all 8 entries.
  always_ff @(posedge clk) begin
    if (load_we)
      buffer[{ld_cnt_q[0], ld_cnt_q[1], ld_cnt_q[2]}] <= swap_ld ? {in_i, in_r} : {in_r, in_i};
    if (calc_we) begin
      buffer[top_idx] <= {bf_out_1_r, bf_out_1_i};
      buffer[bot_idx] <= {bf_out_2_r, bf_out_2_i};
    end
  end

endmodule

// File: tb/tb_fft8_sched.sv
// Directed bench for fft8_sched with a behavioural scaled radix-2 butterfly
// and a reference schedule table; checks latency, schedule, results, stalls and reset.
module tb_fft8_sched;

  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, out_valid, out_ready, out_last, busy;
  logic [7:0] in_r, in_i, out_r, out_i;
  logic [7:0] bf_in_1_r, bf_in_1_i, bf_in_2_r, bf_in_2_i;
  logic [7:0] bf_out_1_r, bf_out_1_i, bf_out_2_r, bf_out_2_i;
  logic [1:0] bf_tw;
  logic       inv;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int t0      = 0;

  logic signed [7:0] xr [8], xi [8], mr [8], mi [8], er [8], ei [8];
  int tops [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int bots [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int tws  [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fft8_sched dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_r(in_r), .in_i(in_i),
    .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .out_i(out_i),
    .out_last(out_last), .busy(busy),
    .bf_in_1_r(bf_in_1_r), .bf_in_1_i(bf_in_1_i), .bf_in_2_r(bf_in_2_r), .bf_in_2_i(bf_in_2_i),
    .bf_tw(bf_tw),
    .bf_out_1_r(bf_out_1_r), .bf_out_1_i(bf_out_1_i), .bf_out_2_r(bf_out_2_r), .bf_out_2_i(bf_out_2_i)
`ifdef FFT8_SCHED_INV_EN
    , .inv(inv)
`endif
  );

  // out_1 = (a + W8^k b)/2, out_2 = (a - W8^k b)/2; 1/sqrt2 approximated by 181/256.
  function automatic logic [31:0] bfly(input logic signed [7:0] ar, ai, br, bi, input logic [1:0] k);
    int a_r, a_i, b_r, b_i, tr, ti;
    logic [7:0] o1r, o1i, o2r, o2i;
    a_r = ar; a_i = ai; b_r = br; b_i = bi;
    case (k)
      2'd0: begin tr = b_r; ti = b_i; end
      2'd1: begin tr = ((b_r + b_i) * 181) >>> 8; ti = ((b_i - b_r) * 181) >>> 8; end
      2'd2: begin tr = b_i; ti = -b_r; end
      default: begin tr = ((b_i - b_r) * 181) >>> 8; ti = (-(b_r + b_i) * 181) >>> 8; end
    endcase
    o1r = 8'((a_r + tr) >>> 1);
    o1i = 8'((a_i + ti) >>> 1);
    o2r = 8'((a_r - tr) >>> 1);
    o2i = 8'((a_i - ti) >>> 1);
    return {o1r, o1i, o2r, o2i};
  endfunction

  always_comb {bf_out_1_r, bf_out_1_i, bf_out_2_r, bf_out_2_i} =
      bfly(bf_in_1_r, bf_in_1_i, bf_in_2_r, bf_in_2_i, bf_tw);

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_frame(input int gap, input logic swp);
    logic [2:0] k3, r3;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk); in_valid = 1'b0; #1;
          chk("ld_gap_ready", {7'd0, in_ready}, 8'd1);
        end
      end
      @(negedge clk);
      in_valid = 1'b1; in_r = xr[k]; in_i = xi[k]; #1;
      if (k == 0) t0 = cyc;
      chk("ld_ready", {7'd0, in_ready}, 8'd1);
      chk("ld_busy", {7'd0, busy}, 8'd0);
      k3 = 3'(k);
      r3 = {k3[0], k3[1], k3[2]};
      mr[r3] = swp ? xi[k] : xr[k];
      mi[r3] = swp ? xr[k] : xi[k];
    end
  endtask

  task automatic calc_check();
    logic [31:0] r;
    int t, b;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      in_valid = 1'b1; in_r = 8'h55; in_i = 8'haa; #1;
      t = tops[c]; b = bots[c];
      chk("calc_busy", {7'd0, busy}, 8'd1);
      chk("calc_in_ready", {7'd0, in_ready}, 8'd0);
      chk("calc_out_valid", {7'd0, out_valid}, 8'd0);
      chk("calc_tw", {6'd0, bf_tw}, 8'(tws[c]));
      chk("calc_a_r", bf_in_1_r, mr[t]);
      chk("calc_a_i", bf_in_1_i, mi[t]);
      chk("calc_b_r", bf_in_2_r, mr[b]);
      chk("calc_b_i", bf_in_2_i, mi[b]);
      r = bfly(mr[t], mi[t], mr[b], mi[b], 2'(tws[c]));
      {mr[t], mi[t], mr[b], mi[b]} = r;
    end
  endtask

  // stall=1 drives out_ready with the repeating pattern 1,0,0,1.
  task automatic unload(input logic stall, input int exp_lat);
    logic [3:0] pat;
    int j, cnt;
    pat = 4'b1001;
    j = 0; cnt = 0;
    while (j < 8 && cnt < 64) begin
      @(negedge clk);
      out_ready = stall ? pat[cnt % 4] : 1'b1; #1;
      if (cnt == 0 && exp_lat != 0) chk("latency", 8'(cyc - t0), 8'(exp_lat));
      chk("ul_valid", {7'd0, out_valid}, 8'd1);
      chk("ul_busy", {7'd0, busy}, 8'd0);
      chk("ul_in_ready", {7'd0, in_ready}, 8'd0);
      chk("ul_out_r", out_r, er[j]);
      chk("ul_out_i", out_i, ei[j]);
      chk("ul_last", {7'd0, out_last}, {7'd0, j == 7});
      if (out_ready) j++;
      cnt++;
    end
    if (j < 8) chk("ul_timeout", 8'(j), 8'd8);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0; #1;
    chk("post_in_ready", {7'd0, in_ready}, 8'd1);
    chk("post_out_valid", {7'd0, out_valid}, 8'd0);
    chk("post_out_r", out_r, 8'd0);
    chk("post_out_last", {7'd0, out_last}, 8'd0);
  endtask

  task automatic set_x(input int idx, input int vr, input int vi, input int fill_r, input int fill_i);
    for (int k = 0; k < 8; k++) begin
      xr[k] = 8'(fill_r); xi[k] = 8'(fill_i);
    end
    xr[idx] = 8'(vr); xi[idx] = 8'(vi);
  endtask

  task automatic set_e(input int vr, input int vi, input int alt);
    for (int k = 0; k < 8; k++) begin
      er[k] = 8'((alt != 0 && k[0]) ? -vr : vr);
      ei[k] = 8'((alt != 0 && k[0]) ? -vi : vi);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_r = '0; in_i = '0; inv = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    chk("rst_in_ready", {7'd0, in_ready}, 8'd0);
    chk("rst_out_valid", {7'd0, out_valid}, 8'd0);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_out_last", {7'd0, out_last}, 8'd0);
    chk("rst_bf_tw", {6'd0, bf_tw}, 8'd0);
    chk("rst_bf_in", bf_in_1_r | bf_in_2_i, 8'd0);
    @(negedge clk); rst = 1'b0; #1;
    chk("rel_in_ready", {7'd0, in_ready}, 8'd1);

    // impulse at x[0]: every bin 8+0j, out_valid 20 cycles after first accept
    set_x(0, 64, 0, 0, 0); set_e(8, 0, 0);
    load_frame(0, 1'b0); calc_check(); unload(1'b0, 20);

    // DC: bin0 = 16, others 0
    set_x(0, 16, 0, 16, 0); set_e(0, 0, 0); er[0] = 8'sd16;
    load_frame(0, 1'b0); calc_check(); unload(1'b0, 20);

    // distinct samples with output backpressure; expectations from reference schedule
    for (int k = 0; k < 8; k++) begin xr[k] = 8'(8 * k); xi[k] = 8'(-4 * k); end
    load_frame(0, 1'b0); calc_check();
    for (int k = 0; k < 8; k++) begin er[k] = mr[k]; ei[k] = mi[k]; end
    unload(1'b1, 20);

    // same samples with 3-cycle input gaps must give the same spectrum
    load_frame(3, 1'b0); calc_check(); unload(1'b0, 0);

    // impulse at x[4]: bins alternate +8/-8
    set_x(4, 64, 0, 0, 0); set_e(8, 0, 1);
    load_frame(0, 1'b0); calc_check(); unload(1'b1, 20);

    // complex impulse 64+32j: every bin 8+4j
    set_x(0, 64, 32, 0, 0); set_e(8, 4, 0);
    load_frame(0, 1'b0); calc_check(); unload(1'b0, 20);

    // abort mid-CALC, then a clean impulse frame
    set_x(0, 16, 0, 16, 0);
    load_frame(0, 1'b0);
    for (int c = 0; c < 5; c++) begin @(negedge clk); in_valid = 1'b0; end
    @(negedge clk); rst = 1'b1; #1;
    chk("abort_busy", {7'd0, busy}, 8'd0);
    chk("abort_in_ready", {7'd0, in_ready}, 8'd0);
    chk("abort_bf_tw", {6'd0, bf_tw}, 8'd0);
    @(negedge clk); rst = 1'b0; #1;
    chk("abort_rel_ready", {7'd0, in_ready}, 8'd1);
    chk("abort_rel_busy", {7'd0, busy}, 8'd0);
    set_x(0, 64, 0, 0, 0); set_e(8, 0, 0);
    load_frame(0, 1'b0); calc_check(); unload(1'b0, 20);

`ifdef FFT8_SCHED_INV_EN
    inv = 1'b1;
    set_x(0, 64, 0, 0, 0); set_e(8, 0, 0);
    load_frame(0, 1'b1); inv = 1'b0; calc_check(); unload(1'b0, 20);
    inv = 1'b0;
    set_x(0, 64, 32, 0, 0); set_e(8, 4, 0);
    load_frame(0, 1'b0); calc_check(); unload(1'b0, 20);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
